// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   INSTR_W / PC_W : instruction and word-address widths
//   NOP_INSTR      : word presented to decode when nothing valid is available
//   q_entry_t      : one queued fetch result {instr, pc}
//   pc_next()      : PC successor, wraps modulo 2^PC_W
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } q_entry_t;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries between the
// instruction memory response and the decode-facing output register.
//   clk, reset (sync, active-low)
//   push / push_entry : write one entry
//   pop               : drop the head entry (ignored when empty)
//   flush             : discard all entries; wins over push
//   head              : current head entry (valid when !empty)
//   count, empty, full: occupancy status
module instr_queue #(
  parameter int QDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_pkg::q_entry_t          push_entry,
  output fetch_pkg::q_entry_t          head,
  output logic [$clog2(QDEPTH):0]      count,
  output logic                         empty,
  output logic                         full
);
  import fetch_pkg::*;

  localparam int AW = $clog2(QDEPTH);

  q_entry_t        mem [QDEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      assert (!(push && full));
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end feeding decode.
//   clk, reset (sync, active-low)
//   stall            : decode cannot accept; output register holds
//   is_branch_taken  : flush queue, kill in-flight read, redirect PC
//   branch_target    : redirect PC, qualified by is_branch_taken
//   imem_req/addr    : read request to synchronous-read instruction memory
//   imem_rdata       : read data, one cycle after imem_req
//   instr/valid/pc   : registered instruction to decode, NOP when invalid
module fetch_unit #(
  parameter logic [fetch_pkg::PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter int                            QDEPTH    = 4,
  parameter logic [fetch_pkg::INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          is_branch_taken,
  input  logic [fetch_pkg::PC_W-1:0]    branch_target,
  output logic                          imem_req,
  output logic [fetch_pkg::PC_W-1:0]    imem_addr,
  input  logic [fetch_pkg::INSTR_W-1:0] imem_rdata,
  output logic [fetch_pkg::INSTR_W-1:0] instr,
  output logic                          instr_valid,
  output logic [fetch_pkg::PC_W-1:0]    instr_pc
);
  import fetch_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [PC_W-1:0] pc_p0;
  logic            vld_p1;
  logic [PC_W-1:0] pc_p1;

  q_entry_t        q_head;
  q_entry_t        resp_entry;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic            q_push;
  logic            q_pop;
  logic            resp_vld;
  logic [CW:0]     occupancy;

  // ---- p0: issue ----
  // Queue entries plus the read still in flight must never exceed QDEPTH,
  // which guarantees every response has a slot.
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, vld_p1};
  assign imem_req  = reset && !is_branch_taken && !q_full &&
                     (occupancy < (CW+1)'(QDEPTH));
  assign imem_addr = pc_p0;

  // ---- p1: response ----
  // A branch in the response cycle kills the returning word.
  assign resp_vld   = vld_p1 && !is_branch_taken;
  assign resp_entry = '{instr: imem_rdata, pc: pc_p1};
  assign q_pop      = !is_branch_taken && !stall && !q_empty;
  // Bypass straight to the output when the queue is empty and decode accepts.
  assign q_push     = resp_vld && (stall || !q_empty);

  instr_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (is_branch_taken),
    .push_entry (resp_entry),
    .head       (q_head),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= imem_req;
      if (is_branch_taken) pc_p0 <= branch_target;
      else if (imem_req)   pc_p0 <= pc_next(pc_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) pc_p1 <= pc_p0;
  end

  // ---- p2: output to decode ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else if (is_branch_taken) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (!q_empty) begin
        instr       <= q_head.instr;
        instr_valid <= 1'b1;
        instr_pc    <= q_head.pc;
      end else if (resp_vld) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        instr_pc    <= pc_p1;
      end else begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end; the producer side of the decode stage's `instr` / `stall` / `is_branch_taken` interface. Keeps the PC and issues reads to a synchronous-read instruction memory. Buffers returned instructions in a small queue, so that a decode stall never loses an in-flight word. Presents one 16-bit instruction per cycle to decode, with NOP (16'h0000) substituted when nothing is valid.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `QDEPTH`, 4: instruction queue entries (power of two, ≥2).
- `NOP_INSTR`, 16'h0000: word driven when `instr_valid`=0 (opcode 0 = NOP in decode).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `stall` in 1: decode cannot accept; output held.
- `is_branch_taken` in 1: redirect/flush request from execute.
- `branch_target` in 16: redirect PC, valid with `is_branch_taken`.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 16: word address of request.
- `imem_rdata` in 16: read data, valid exactly 1 cycle after `imem_req`.
- `instr` out 16: instruction to decode (registered).
- `instr_valid` out 1: `instr` is a real fetched word.
- `instr_pc` out 16: address of `instr`.

## Operation
- PC is word-addressed; it advances +1 per issued request and wraps 16'hFFFF→16'h0000 modulo 2^16.
- Issue rule: `imem_req`=1 when `reset` is high, `is_branch_taken`=0, and (queue count + inflight) < QDEPTH. `imem_addr`=PC. The PC increments on that edge.
- inflight flag: set on issue, cleared the next cycle. On the response cycle, {`imem_rdata`, issued PC} is pushed into the queue unless killed.
- Output register update each edge, in priority order:
  - reset low: `instr`=NOP_INSTR, `instr_valid`=0, `instr_pc`=0. Queue emptied, inflight cleared, PC=RESET_PC.
  - `is_branch_taken`: `instr`=NOP_INSTR, `instr_valid`=0. Queue flushed. Any in-flight response is killed and not pushed. PC=`branch_target`. No request this cycle.
  - `stall`=1: output registers hold. Pushes still occur.
  - otherwise: if queue is non-empty, pop the head into the output. Else, if an unkilled response arrives this cycle, bypass it directly into the output. Else load NOP_INSTR with `instr_valid`=0.
- Push and pop in the same cycle are allowed. With the issue rule, a push into a full queue cannot occur; an assertion checks this.
- Ordering: words reach `instr` in strict PC order, with no loss or duplication across any stall pattern.
- Reset mid-operation: all state is discarded and the in-flight response is ignored. The first request goes to RESET_PC in the first cycle with `reset` high.

## Timing
- Request at cycle N → data at N+1 → `instr` visible after edge N+1 (latency 2 from request), when there is no stall and the queue is empty.
- Steady state: 1 instruction/cycle.
- Redirect: `is_branch_taken` at cycle B → `instr`=NOP at B+1. Request to target at B+1; target instruction on `instr` at B+3.
- `stall` and `is_branch_taken` in the same cycle: the branch wins.
- Stall held ≥ QDEPTH+1 cycles: the queue fills to QDEPTH, then `imem_req` stays 0. The first request after release occurs in the cycle after the first pop.

## Structure
- Package `fetch_pkg`: `NOP_INSTR`, `INSTR_W`=16, `PC_W`=16, and a queue entry struct {instr[15:0], pc[15:0]}.
- Sub-module `instr_queue`: synchronous FIFO.
  - Parameter QDEPTH; push/pop/flush.
  - Outputs count, empty, full, head.
  - Wrap-around pointers with an extra MSB bit.
  - Flush has priority over push.
- `fetch_unit` holds the PC, inflight/kill flag, issue logic, and output registers.

## Test plan
- Reset: hold `reset`=0 for 3 cycles. Then `instr`=16'h0000, `instr_valid`=0, `instr_pc`=0. First cycle with `reset`=1: `imem_req`=1, `imem_addr`=16'h0000.
- Straight line: mem[i]=16'h1000+i, no stall. `instr` = 16'h1000, 16'h1001, 16'h1002… on consecutive cycles from cycle 2, with `instr_pc` = 0, 1, 2….
- Stall: assert `stall` for 6 cycles mid-stream while output holds 16'h1003. Output holds; `imem_req` drops after the queue reaches 4. After release, 16'h1004…16'h1009 appear contiguously with no gap, loss, or duplicate.
- Branch with a response in flight: `is_branch_taken`=1, `branch_target`=16'h0040 at cycle B. `instr`=NOP / `instr_valid`=0 at B+1. The killed word never appears. mem[0x40] appears at B+3 with `instr_pc`=16'h0040.
- Simultaneous: `stall`=1 and `is_branch_taken`=1 with target 16'h0080. Behaviour is identical to a branch alone: queue flushed, `instr`=NOP next cycle.
- Wrap: branch to 16'hFFFE. `instr_pc` sequence is FFFE, FFFF, 0000, 0001 with the matching mem words.
